// File: rtl/bitmap_addr_encoder.sv
// -----------------------------------------------------------------------------
// bitmap_addr_encoder
//
// Sequential inverse of the multi-hot decoder. It latches a SIZE-bit multi-hot
// vector on start and scans it one bit per clock, lowest index first. The index
// of each set bit is packed into the next free BIT-wide slot of addr_out until
// K slots are filled. Any set bit found after that raises overflow instead.
//
// Ports
//   clk      : rising-edge clock
//   rst      : synchronous, active-high reset
//   start    : begin a conversion; sampled only in IDLE
//   in_vec   : multi-hot vector, latched on the start-accept edge
//   busy     : high in SCAN and DONE
//   done     : one-cycle pulse; results are valid from this cycle on
//   addr_out : packed indices, slot i = addr_out[BIT*(i+1)-1 : BIT*i]
//   count    : number of valid slots, 0..K
//   overflow : in_vec held more than K set bits
// -----------------------------------------------------------------------------
module bitmap_addr_encoder #(
  parameter int SIZE = 8,
  parameter int K    = 4,
  parameter int BIT  = $clog2(SIZE),
  parameter int CW   = $clog2(K + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   in_vec,
  output logic              busy,
  output logic              done,
  output logic [K*BIT-1:0]  addr_out,
  output logic [CW-1:0]     count,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [BIT-1:0] LAST_IDX = BIT'(SIZE - 1);
  localparam logic [CW-1:0]  K_SLOTS  = CW'(K);

  state_t            state_q, state_d;
  logic [BIT-1:0]    idx_q;
  logic [SIZE-1:0]   vec_q;
  logic [K*BIT-1:0]  addr_q;
  logic [CW-1:0]     count_q;
  logic              overflow_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of the
  // order in which the always blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; without it synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: latched vector, scan index and packed results
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      vec_q      <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Results are held here until a new conversion is accepted.
          if (start) begin
            vec_q      <= in_vec;
            idx_q      <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
          end
        end
        SCAN: begin
          if (vec_q[idx_q]) begin
            if (count_q < K_SLOTS) begin
              addr_q[count_q*BIT +: BIT] <= idx_q;
              count_q                    <= count_q + 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
          end
          // The terminal compare stops idx before it could wrap.
          if (idx_q != LAST_IDX) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign addr_out = addr_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bitmap_addr_encoder.sv
// -----------------------------------------------------------------------------
// tb_bitmap_addr_encoder
//
// Self-checking bench for bitmap_addr_encoder (SIZE=8, K=4). Directed vectors
// plus random vectors are compared against a reference that lists the set-bit
// positions of the vector directly. Latency, busy length, done pulse width,
// result hold in IDLE, ignored start, ignored in_vec changes and reset abort
// are all checked.
// -----------------------------------------------------------------------------
module tb_bitmap_addr_encoder;

  localparam int SIZE = 8;
  localparam int K    = 4;
  localparam int BIT  = $clog2(SIZE);
  localparam int CW   = $clog2(K + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [SIZE-1:0]   in_vec;
  logic              busy;
  logic              done;
  logic [K*BIT-1:0]  addr_out;
  logic [CW-1:0]     count;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;

  bitmap_addr_encoder #(.SIZE(SIZE), .K(K)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_vec   (in_vec),
    .busy     (busy),
    .done     (done),
    .addr_out (addr_out),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the vector, collect positions of set bits into a queue,
  // then pack the first K of them.
  task automatic ref_model(input logic [SIZE-1:0] v,
                           output logic [K*BIT-1:0] exp_addr,
                           output int exp_cnt, output bit exp_ovf);
    int pos[$];
    for (int i = 0; i < SIZE; i++)
      if (v[i]) pos.push_back(i);
    exp_addr = '0;
    exp_cnt  = (pos.size() > K) ? K : pos.size();
    exp_ovf  = (pos.size() > K);
    for (int s = 0; s < exp_cnt; s++)
      exp_addr[s*BIT +: BIT] = BIT'(pos[s]);
  endtask

  // Sample point: #1 after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one conversion. If ignore_at > 0, start is re-pulsed with
  // ignore_vec on that scan cycle (must be ignored). in_vec is scrambled
  // after acceptance when scramble is set.
  task automatic run_conv(input string tag, input logic [SIZE-1:0] v,
                          input int ignore_at, input logic [SIZE-1:0] ignore_vec,
                          input bit scramble);
    logic [K*BIT-1:0] e_addr;
    int               e_cnt;
    bit               e_ovf;
    int               edges;
    int               busy_cyc;
    bit               seen;
    ref_model(v, e_addr, e_cnt, e_ovf);
    @(negedge clk);
    start  = 1'b1;
    in_vec = v;
    edges    = 0;
    busy_cyc = 0;
    seen     = 1'b0;
    while (edges < 40) begin
      tick();
      edges++;
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
        break;
      end
      @(negedge clk);
      start = (ignore_at > 0 && edges == ignore_at) ? 1'b1 : 1'b0;
      if (ignore_at > 0 && edges == ignore_at) in_vec = ignore_vec;
      else if (scramble) in_vec = SIZE'($urandom);
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"},   32'(edges), 32'(SIZE + 1));
    check({tag, " busy_cyc"},  32'(busy_cyc), 32'(SIZE + 1));
    check({tag, " addr"},      32'(addr_out), 32'(e_addr));
    check({tag, " count"},     32'(count), 32'(e_cnt));
    check({tag, " overflow"},  32'(overflow), 32'(e_ovf));
    // One-cycle pulse, then results held in IDLE.
    tick();
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " idle_busy"},  32'(busy), 32'd0);
    in_vec = SIZE'($urandom);
    repeat (2) tick();
    check({tag, " hold_addr"},  32'(addr_out), 32'(e_addr));
    check({tag, " hold_count"}, 32'(count), 32'(e_cnt));
    check({tag, " hold_ovf"},   32'(overflow), 32'(e_ovf));
  endtask

  initial begin
    bit done_hit;
    rst    = 1'b1;
    start  = 1'b0;
    in_vec = '0;
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    check("reset busy",     32'(busy), 32'd0);
    check("reset done",     32'(done), 32'd0);
    check("reset addr",     32'(addr_out), 32'd0);
    check("reset count",    32'(count), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);

    run_conv("vec_a6", 8'b1010_0110, 0, '0, 1'b0);
    run_conv("vec_ff", 8'hFF, 0, '0, 1'b0);
    run_conv("vec_00", 8'h00, 0, '0, 1'b0);
    run_conv("vec_80_ign", 8'h80, 3, 8'h01, 1'b0);
    run_conv("vec_01", 8'h01, 0, '0, 1'b0);

    // Reset during the 4th SCAN cycle aborts without a done pulse.
    @(negedge clk);
    start  = 1'b1;
    in_vec = 8'hF0;
    tick();                 // E0
    @(negedge clk);
    start = 1'b0;
    repeat (3) tick();      // E1..E3
    @(negedge clk);
    rst = 1'b1;
    tick();                 // 4th SCAN edge, reset wins
    check("abort busy",  32'(busy), 32'd0);
    check("abort count", 32'(count), 32'd0);
    check("abort addr",  32'(addr_out), 32'd0);
    check("abort ovf",   32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_hit = 1'b0;
    repeat (12) begin
      tick();
      if (done) done_hit = 1'b1;
    end
    check("abort no_done", 32'(done_hit), 32'd0);
    run_conv("vec_0c", 8'h0C, 0, '0, 1'b0);

    // rst and start on the same edge: reset wins, nothing starts.
    @(negedge clk);
    rst    = 1'b1;
    start  = 1'b1;
    in_vec = 8'h55;
    tick();
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("rst_start busy", 32'(busy), 32'd0);

    for (int t = 0; t < 40; t++)
      run_conv($sformatf("rand%0d", t), SIZE'($urandom), 0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
